// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is instruction fetch, port 1 is data.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    // When both ports are pending the tie goes to 'prio'
    function automatic logic pick_port(
        input logic pend0,
        input logic pend1,
        input logic prio
    );
        if (pend0 && pend1) begin
            return prio;
        end
        return pend0 ? PORT_IFETCH : PORT_DATA;
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One requester's pending slot: latches a request pulse, reports busy,
// and frees itself on the completion pulse.
module mem_arb_slot
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic              wr_req_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output req_type_e         type_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    req_type_e         type_q, type_d;
    logic              accept;

    // Freed in the ack cycle so a fresh pulse there is taken
    assign busy_o = valid_q & ~clr_i;
    assign accept = (rd_req_i | wr_req_i) & ~busy_o;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        if (accept) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = wr_data_i;
            type_d  = wr_req_i ? REQ_WR : REQ_RD;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= REQ_RD;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign type_o = type_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (ifetch/data) arbiter onto a single request/ack memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; default is p0 wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    input  logic              p0_rd_req,
    input  logic              p0_wr_req,
    output logic [DATA_W-1:0] p0_rd_data,
    output logic              p0_ack,
    output logic              p0_busy,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    input  logic              p1_rd_req,
    input  logic              p1_wr_req,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              p1_ack,
    output logic              p1_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ack,
    input  logic              mem_busy
);

    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    req_type_e         type0, type1, gnt_type;
    logic              gnt_sel;

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (p0_addr),
        .wr_data_i (p0_wr_data),
        .rd_req_i  (p0_rd_req),
        .wr_req_i  (p0_wr_req),
        .clr_i     (ack_q[PORT_IFETCH]),
        .busy_o    (p0_busy),
        .addr_o    (addr0),
        .data_o    (data0),
        .type_o    (type0)
    );

    mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (p1_addr),
        .wr_data_i (p1_wr_data),
        .rd_req_i  (p1_rd_req),
        .wr_req_i  (p1_wr_req),
        .clr_i     (ack_q[PORT_DATA]),
        .busy_o    (p1_busy),
        .addr_o    (addr1),
        .data_o    (data1),
        .type_o    (type1)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    assign gnt_sel = pick_port(p0_busy, p1_busy, ptr_q);
`else
    assign gnt_sel = pick_port(p0_busy, p1_busy, PORT_IFETCH);
`endif

    assign gnt_type = (gnt_q == PORT_DATA) ? type1 : type0;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        maddr_d    = maddr_q;
        mdata_d    = mdata_q;
        ack_d      = '0;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if ((p0_busy | p1_busy) && !mem_busy) begin
                    gnt_d   = gnt_sel;
                    maddr_d = (gnt_sel == PORT_DATA) ? addr1 : addr0;
                    mdata_d = (gnt_sel == PORT_DATA) ? data1 : data0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_req = (gnt_type == REQ_RD);
                mem_wr_req = (gnt_type == REQ_WR);
                state_d    = WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    ack_d[gnt_q] = 1'b1;
                    if (gnt_type == REQ_RD) begin
                        if (gnt_q == PORT_DATA) begin
                            rd1_d = mem_rd_data;
                        end else begin
                            rd0_d = mem_rd_data;
                        end
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d = ~ptr_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= PORT_IFETCH;
            maddr_q <= '0;
            mdata_q <= '0;
            ack_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q   <= PORT_IFETCH;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            ack_q   <= ack_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign p0_ack      = ack_q[PORT_IFETCH];
    assign p1_ack      = ack_q[PORT_DATA];
    assign p0_rd_data  = rd0_q;
    assign p1_rd_data  = rd1_q;
    assign mem_addr    = maddr_q;
    assign mem_wr_data = mdata_q;

endmodule
